object_line_scanner: RTL and testbench



---
 rtl/object_line_scanner.sv | 189 ++++++++++++++++++
 tb/tb_object_line_scanner.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/object_line_scanner.sv
// object_line_scanner: per-frame object snapshot, per-line visibility scan and registered per-pixel hit lookup.
// Define OBJ_OVERFLOW_COUNT_EN to enable the saturating overflow_cnt counter.
module object_line_scanner #(
  parameter int NUM_OBJ      = 15,
  parameter int OBJ_SIZE     = 32,
  parameter int OFS_W        = 5,
  parameter int MAX_PER_LINE = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 frame_start,
  input  logic                 line_start,
  input  logic [9:0]           next_line,
  input  logic [9:0]           draw_x,
  input  logic [10*NUM_OBJ-1:0] obj_x,
  input  logic [10*NUM_OBJ-1:0] obj_y,
  input  logic [3*NUM_OBJ-1:0]  obj_state,
  output logic                 hit,
  output logic [3:0]           hit_idx,
  output logic [2:0]           hit_state,
  output logic [OFS_W-1:0]     hit_dx,
  output logic [OFS_W-1:0]     hit_dy,
  output logic                 scan_busy,
  output logic                 line_overflow,
  output logic [7:0]           overflow_cnt
);
  localparam int CW = $clog2(MAX_PER_LINE + 1);
  localparam int AW = $clog2(MAX_PER_LINE);
  typedef enum logic [1:0] {IDLE, SCAN, SWAP} state_t;
  typedef struct packed {
    logic [3:0]       idx;
    logic [9:0]       x;
    logic [2:0]       st;
    logic [OFS_W-1:0] dy;
  } ent_t;
  logic [9:0]       sx_q [NUM_OBJ];
  logic [9:0]       sx_d [NUM_OBJ];
  logic [9:0]       sy_q [NUM_OBJ];
  logic [9:0]       sy_d [NUM_OBJ];
  logic [2:0]       ss_q [NUM_OBJ];
  logic [2:0]       ss_d [NUM_OBJ];
  ent_t             bl_q [MAX_PER_LINE];
  ent_t             bl_d [MAX_PER_LINE];
  ent_t             al_q [MAX_PER_LINE];
  ent_t             al_d [MAX_PER_LINE];
  state_t           state_q, state_d;
  logic [9:0]       line_q, line_d;
  logic [3:0]       idx_q, idx_d;
  logic [CW-1:0]    bcnt_q, bcnt_d, acnt_q, acnt_d;
  logic             bovf_q, bovf_d, lovf_q, lovf_d;
  logic             hit_q, hit_d;
  logic [3:0]       hidx_q, hidx_d;
  logic [2:0]       hst_q, hst_d;
  logic [OFS_W-1:0] hdx_q, hdx_d, hdy_q, hdy_d;
  logic [9:0]       cur_x, cur_y;
  logic [2:0]       cur_st;
  logic             vis;
  always_comb begin
    sx_d = sx_q;
    sy_d = sy_q;
    ss_d = ss_q;
    if (frame_start)
      for (int i = 0; i < NUM_OBJ; i++) begin
        sx_d[i] = obj_x[10*i +: 10];
        sy_d[i] = obj_y[10*i +: 10];
        ss_d[i] = obj_state[3*i +: 3];
      end
  end
  // 11-bit compares so objects near the 1023 edge never wrap onto low lines
  always_comb begin
    cur_x  = sx_q[idx_q - 4'd1];
    cur_y  = sy_q[idx_q - 4'd1];
    cur_st = ss_q[idx_q - 4'd1];
    vis    = (cur_st != 3'd0) && ({1'b0, line_q} >= {1'b0, cur_y}) &&
             ({1'b0, line_q} < {1'b0, cur_y} + 11'(OBJ_SIZE));
  end
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    bovf_d  = bovf_q;
    bl_d    = bl_q;
    al_d    = al_q;
    acnt_d  = acnt_q;
    lovf_d  = lovf_q;
    if (line_start) begin
      state_d = SCAN;
      line_d  = next_line;
      idx_d   = 4'd1;
      bcnt_d  = '0;
      bovf_d  = 1'b0;
    end else if (state_q == SCAN) begin
      if (vis && bcnt_q < CW'(MAX_PER_LINE)) begin
        bl_d[bcnt_q[AW-1:0]] = '{idx: idx_q, x: cur_x, st: cur_st, dy: OFS_W'(line_q - cur_y)};
        bcnt_d = bcnt_q + CW'(1);
      end else if (vis) begin
        bovf_d = 1'b1;
      end
      state_d = (idx_q == 4'(NUM_OBJ)) ? SWAP : SCAN;
      idx_d   = idx_q + 4'd1;
    end else if (state_q == SWAP) begin
      al_d    = bl_q;
      acnt_d  = bcnt_q;
      lovf_d  = bovf_q;
      state_d = IDLE;
    end
  end
  // Iterate high to low so the lowest matching slot overrides the rest
  always_comb begin
    hit_d  = 1'b0;
    hidx_d = '0;
    hst_d  = '0;
    hdx_d  = '0;
    hdy_d  = '0;
    for (int k = MAX_PER_LINE - 1; k >= 0; k--)
      if (CW'(k) < acnt_q && {1'b0, draw_x} >= {1'b0, al_q[k].x} &&
          {1'b0, draw_x} < {1'b0, al_q[k].x} + 11'(OBJ_SIZE)) begin
        hit_d  = 1'b1;
        hidx_d = al_q[k].idx;
        hst_d  = al_q[k].st;
        hdx_d  = OFS_W'(draw_x - al_q[k].x);
        hdy_d  = al_q[k].dy;
      end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        sx_q[i] <= '0;
        sy_q[i] <= '0;
        ss_q[i] <= '0;
      end
      for (int k = 0; k < MAX_PER_LINE; k++) begin
        bl_q[k] <= '0;
        al_q[k] <= '0;
      end
      state_q <= IDLE;
      line_q  <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      acnt_q  <= '0;
      bovf_q  <= 1'b0;
      lovf_q  <= 1'b0;
      hit_q   <= 1'b0;
      hidx_q  <= '0;
      hst_q   <= '0;
      hdx_q   <= '0;
      hdy_q   <= '0;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      ss_q    <= ss_d;
      bl_q    <= bl_d;
      al_q    <= al_d;
      state_q <= state_d;
      line_q  <= line_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      acnt_q  <= acnt_d;
      bovf_q  <= bovf_d;
      lovf_q  <= lovf_d;
      hit_q   <= hit_d;
      hidx_q  <= hidx_d;
      hst_q   <= hst_d;
      hdx_q   <= hdx_d;
      hdy_q   <= hdy_d;
    end
  end
  assign hit           = hit_q;
  assign hit_idx       = hidx_q;
  assign hit_state     = hst_q;
  assign hit_dx        = hdx_q;
  assign hit_dy        = hdy_q;
  assign scan_busy     = (state_q != IDLE);
  assign line_overflow = lovf_q;
`ifdef OBJ_OVERFLOW_COUNT_EN
  logic [7:0] ocnt_q, ocnt_d;
  always_comb
    ocnt_d = frame_start ? 8'd0 :
             (state_q == SWAP && !line_start && bovf_q && ocnt_q != 8'hff) ? ocnt_q + 8'd1 : ocnt_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ocnt_q <= '0;
    else          ocnt_q <= ocnt_d;
  end
  assign overflow_cnt = ocnt_q;
`else
  assign overflow_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_object_line_scanner.sv
// tb_object_line_scanner: directed table, corner sequences and randomized scans against a list-based reference model.
module tb_object_line_scanner;
  logic clk = 1'b0, reset_n = 1'b0, frame_start = 1'b0, line_start = 1'b0;
  logic [9:0] next_line = '0, draw_x = '0;
  logic [149:0] obj_x = '0, obj_y = '0;
  logic [44:0] obj_state = '0;
  logic hit, scan_busy, line_overflow;
  logic [3:0] hit_idx;
  logic [2:0] hit_state;
  logic [4:0] hit_dx, hit_dy;
  logic [7:0] overflow_cnt;
  int checks = 0, failures = 0;
  int ix[16], iy[16], is[16], sx[16], sy[16], ss[16];
  int ai[$], ax[$], ast[$], ady[$];
  int m_ovf = 0, m_cnt = 0;
  typedef struct { int x; int h; int id; int st; int dx; int dy; } vec_t;
  vec_t tv[5];

  always #5 clk = ~clk;

  object_line_scanner dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .line_start(line_start),
    .next_line(next_line), .draw_x(draw_x), .obj_x(obj_x), .obj_y(obj_y), .obj_state(obj_state),
    .hit(hit), .hit_idx(hit_idx), .hit_state(hit_state), .hit_dx(hit_dx), .hit_dy(hit_dy),
    .scan_busy(scan_busy), .line_overflow(line_overflow), .overflow_cnt(overflow_cnt)
  );

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic put_obj(input int i, input int x, input int y, input int s);
    ix[i] = x; iy[i] = y; is[i] = s;
    obj_x[10*(i-1) +: 10] = 10'(x);
    obj_y[10*(i-1) +: 10] = 10'(y);
    obj_state[3*(i-1) +: 3] = 3'(s);
  endtask

  task automatic clear_objs();
    for (int i = 1; i <= 15; i++) put_obj(i, 0, 0, 0);
  endtask

  task automatic take_snapshot();
    for (int i = 1; i <= 15; i++) begin sx[i] = ix[i]; sy[i] = iy[i]; ss[i] = is[i]; end
    m_cnt = 0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    take_snapshot();
  endtask

  task automatic exp_pix(input int x, output int h, output int id, output int st, output int dx, output int dy);
    h = 0; id = 0; st = 0; dx = 0; dy = 0;
    for (int k = 0; k < ai.size(); k++)
      if (x >= ax[k] && x < ax[k] + 32) begin
        h = 1; id = ai[k]; st = ast[k]; dx = x - ax[k]; dy = ady[k];
        break;
      end
  endtask

  task automatic check_pix(input int x);
    int h, id, st, dx, dy;
    draw_x = 10'(x);
    @(negedge clk);
    exp_pix(x, h, id, st, dx, dy);
    chk($sformatf("hit@%0d", x), hit, h);
    chk($sformatf("hit_idx@%0d", x), hit_idx, id);
    chk($sformatf("hit_state@%0d", x), hit_state, st);
    chk($sformatf("hit_dx@%0d", x), hit_dx, dx);
    chk($sformatf("hit_dy@%0d", x), hit_dy, dy);
  endtask

  task automatic build_model(input int line);
    ai.delete(); ax.delete(); ast.delete(); ady.delete();
    m_ovf = 0;
    for (int i = 1; i <= 15; i++)
      if (ss[i] != 0 && line >= sy[i] && line < sy[i] + 32) begin
        if (ai.size() < 4) begin
          ai.push_back(i); ax.push_back(sx[i]); ast.push_back(ss[i]); ady.push_back(line - sy[i]);
        end else m_ovf = 1;
      end
    if (m_ovf == 1 && m_cnt < 255) m_cnt++;
  endtask

  // Full scan; while busy, draw_x is held at probe and hits must still follow the old list.
  task automatic scan(input int line, input int probe, input bit fr);
    int h, id, st, dx, dy, busy, bad;
    line_start = 1'b1;
    frame_start = fr;
    next_line = 10'(line);
    @(negedge clk);
    line_start = 1'b0;
    frame_start = 1'b0;
    if (fr) take_snapshot();
    draw_x = 10'(probe);
    exp_pix(probe, h, id, st, dx, dy);
    busy = 0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (scan_busy) busy++;
      if (i > 0 && (hit != h || hit_idx != id || hit_dx != dx)) bad++;
      @(negedge clk);
    end
    chk($sformatf("busy_cycles@line%0d", line), busy, 16);
    chk($sformatf("old_list_hits@line%0d", line), bad, 0);
    chk($sformatf("busy_done@line%0d", line), scan_busy, 0);
    build_model(line);
    chk($sformatf("line_overflow@line%0d", line), line_overflow, m_ovf);
`ifdef OBJ_OVERFLOW_COUNT_EN
    chk("overflow_cnt", overflow_cnt, m_cnt);
`else
    chk("overflow_cnt", overflow_cnt, 0);
`endif
  endtask

  initial begin
    int n, line, lo, hi, px;
    tv[0] = '{x: 99,  h: 0, id: 0, st: 0, dx: 0,  dy: 0};
    tv[1] = '{x: 100, h: 1, id: 3, st: 2, dx: 0,  dy: 10};
    tv[2] = '{x: 110, h: 1, id: 3, st: 2, dx: 10, dy: 10};
    tv[3] = '{x: 131, h: 1, id: 3, st: 2, dx: 31, dy: 10};
    tv[4] = '{x: 132, h: 0, id: 0, st: 0, dx: 0,  dy: 0};
    clear_objs();
    take_snapshot();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_hit", hit, 0);
    chk("rst_hit_idx", hit_idx, 0);
    chk("rst_hit_state", hit_state, 0);
    chk("rst_hit_dx", hit_dx, 0);
    chk("rst_hit_dy", hit_dy, 0);
    chk("rst_scan_busy", scan_busy, 0);
    chk("rst_line_overflow", line_overflow, 0);
    chk("rst_overflow_cnt", overflow_cnt, 0);
    n = 0;
    for (int x = 0; x < 640; x++) begin
      draw_x = 10'(x);
      @(negedge clk);
      if (hit || hit_idx != 0) n++;
    end
    chk("empty_list_hits", n, 0);

    put_obj(3, 100, 50, 2);
    frame();
    scan(60, 0, 1'b0);
    for (int v = 0; v < 5; v++) begin
      draw_x = 10'(tv[v].x);
      @(negedge clk);
      chk($sformatf("tbl_hit@%0d", tv[v].x), hit, tv[v].h);
      chk($sformatf("tbl_idx@%0d", tv[v].x), hit_idx, tv[v].id);
      chk($sformatf("tbl_state@%0d", tv[v].x), hit_state, tv[v].st);
      chk($sformatf("tbl_dx@%0d", tv[v].x), hit_dx, tv[v].dx);
      chk($sformatf("tbl_dy@%0d", tv[v].x), hit_dy, tv[v].dy);
    end

    clear_objs();
    put_obj(5, 200, 0, 1);
    put_obj(2, 200, 0, 1);
    frame();
    scan(0, 110, 1'b0);
    check_pix(200);
    chk("lower_index_wins", hit_idx, 2);

    clear_objs();
    foreach (tv[v]) ;
    put_obj(1, 40, 0, 1);
    put_obj(4, 160, 1, 4);
    put_obj(6, 240, 2, 6);
    put_obj(8, 320, 3, 1);
    put_obj(9, 360, 4, 2);
    put_obj(12, 480, 5, 5);
    frame();
    scan(10, 200, 1'b0);
    chk("six_visible_overflow", line_overflow, 1);
    foreach (ix[i]) if (is[i] != 0) check_pix(ix[i] + 3);
    frame();
    chk("overflow_cnt_cleared", overflow_cnt, 0);
    scan(40, 0, 1'b0);

    clear_objs();
    put_obj(7, 1000, 1000, 3);
    put_obj(9, 300, 3, 0);
    frame();
    scan(5, 0, 1'b0);
    check_pix(1005);
    check_pix(5);
    check_pix(310);
    scan(1023, 0, 1'b0);
    check_pix(1020);
    check_pix(3);
    check_pix(310);

    clear_objs();
    put_obj(10, 400, 30, 6);
    scan(40, 1020, 1'b1);
    check_pix(405);

    clear_objs();
    put_obj(1, 50, 15, 4);
    put_obj(2, 60, 100, 5);
    frame();
    scan(110, 0, 1'b0);
    line_start = 1'b1;
    next_line = 10'd110;
    @(negedge clk);
    line_start = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_scan_busy", scan_busy, 1);
    scan(20, 65, 1'b0);
    check_pix(65);

    for (int r = 0; r < 25; r++) begin
      line = $urandom_range(0, 1023);
      lo = (line > 40) ? line - 40 : 0;
      hi = (line < 1015) ? line + 8 : 1023;
      for (int i = 1; i <= 15; i++)
        put_obj(i, $urandom_range(0, 1023), $urandom_range(lo, hi),
                ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 7));
      frame();
      scan(line, $urandom_range(0, 1023), 1'b0);
      for (int k = 0; k < ai.size(); k++) begin
        check_pix(ax[k]);
        px = ax[k] + 31;
        check_pix(px > 1023 ? 1023 : px);
        px = ax[k] + 32;
        if (px <= 1023) check_pix(px);
      end
      repeat (6) check_pix($urandom_range(0, 1023));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
